urxd_param: RTL

Parametrised UART receiver: the next generation of the single-format 8N1 receiver. It runs on one clock and reconstructs frames from an asynchronous serial input. Data width, parity mode, stop-bit count, baud rate and oversampling ratio are all configurable. It adds glitch rejection, parity and framing error reporting, and break-lockout. It sits at the serial pin or in TX→RX loopback test schematics, and keeps the debug outputs those schematics probe.

---
 rtl/urxd_param.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/urxd_param.sv
// urxd_param -- parametrised UART receiver.
//
// Rebuilds frames of DATA_BITS payload bits (LSB first), optional parity
// (PARITY: 0 none, 1 odd, 2 even) and STOP_BITS stop bits from the
// asynchronous line Inp. The line is oversampled OVS times per bit, and the
// oversampling tick is derived from CLK_HZ / (BAUD * OVS).
// After a frame that ends with the line low, the receiver stays locked out
// until the line returns high.
//
// Optional build macro: URXD_MAJ3_EN. When defined, each bit sample is a
// three-tick majority vote. When undefined, a single tick is sampled.
//
// Ports:
//   clk         single clock
//   rst_n       asynchronous active-low reset
//   Inp         serial line, asynchronous, idles high
//   dat         last received payload, held until the next frame end
//   ok_rx_byte  one-clk pulse: frame received without errors
//   err_frame   one-clk pulse: a stop bit was sampled low
//   err_parity  one-clk pulse: parity mismatch
//   en_rx_byte  high while a frame is in progress
//   cb_bit      bit index: 0 = start, then data, parity, stop bits
//   ce_tact     oversampling tick strobe (debug)
//   ce_bit      mid-bit sample strobe (debug)
//   RXD         synchronised line value (debug)
//
// state | meaning
// IDLE  | line idle, looking for a low level on a tick
// START | inside the start bit, confirming it at mid-bit
// DATA  | sampling payload bits
// PAR   | sampling the parity bit
// STOP  | sampling stop bits; the frame ends at the last stop mid-bit
// BRK   | frame ended with the line low, waiting for it to go high
module urxd_param #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int OVS       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 Inp,
  output logic [DATA_BITS-1:0] dat,
  output logic                 ok_rx_byte,
  output logic                 err_frame,
  output logic                 err_parity,
  output logic                 en_rx_byte,
  output logic [3:0]           cb_bit,
  output logic                 ce_tact,
  output logic                 ce_bit,
  output logic                 RXD
);

  localparam int N_RAW = CLK_HZ / (BAUD * OVS);
  localparam int N     = (N_RAW < 1) ? 1 : N_RAW;
  localparam int DIV_W = (N > 1) ? $clog2(N) : 1;
  localparam int CT_W  = $clog2(OVS);

  localparam logic [DIV_W-1:0] DIV_MAX      = DIV_W'(N - 1);
  localparam logic [CT_W-1:0]  CT_MAX       = CT_W'(OVS - 1);
  localparam logic [CT_W-1:0]  CT_MID       = CT_W'(OVS / 2 - 1);
  localparam logic [3:0]       CB_LAST_DATA = 4'(DATA_BITS);
  localparam logic [3:0]       CB_LAST_STOP =
    4'(DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK
  } state_e;

  state_e                state_q, state_d;
  logic                  sync1_q, rxd_q;
  logic [DIV_W-1:0]      div_q;
  logic [CT_W-1:0]       ct_q, ct_d;
  logic [3:0]            cb_q, cb_d;
  logic [DATA_BITS-1:0]  sh_q, sh_d;
  logic [DATA_BITS-1:0]  dat_q, dat_d;
  logic                  fe_q, fe_d;
  logic                  pe_q, pe_d;
  logic                  ok_q, ok_d;
  logic                  fer_q, fer_d;
  logic                  per_q, per_d;
  logic                  samp;
  logic                  par_exp;
  logic                  fe_stop;

  // Two-flop synchroniser; resets to the idle level so reset release never
  // looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rxd_q   <= 1'b1;
    end else begin
      sync1_q <= Inp;
      rxd_q   <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              div_q <= '0;
    else if (div_q == DIV_MAX) div_q <= '0;
    else                     div_q <= div_q + DIV_W'(1);
  end

  assign ce_tact = (div_q == DIV_MAX);
  assign ce_bit  = ce_tact && (ct_q == CT_MID);

`ifdef URXD_MAJ3_EN
  logic h1_q, h2_q;

  // Vote over the three ticks ending at the sample tick, so the decision
  // falls on the same clk as in the single-sample build.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1_q <= 1'b1;
      h2_q <= 1'b1;
    end else if (ce_tact) begin
      h1_q <= rxd_q;
      h2_q <= h1_q;
    end
  end

  assign samp = (rxd_q & h1_q) | (rxd_q & h2_q) | (h1_q & h2_q);
`else
  assign samp = rxd_q;
`endif

  // Even parity expects the XOR of the payload, odd parity its inverse.
  assign par_exp = (PARITY == 2) ? (^sh_q) : ~(^sh_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ct_q    <= '0;
      cb_q    <= '0;
      sh_q    <= '0;
      dat_q   <= '0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ok_q    <= 1'b0;
      fer_q   <= 1'b0;
      per_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ct_q    <= ct_d;
      cb_q    <= cb_d;
      sh_q    <= sh_d;
      dat_q   <= dat_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      ok_q    <= ok_d;
      fer_q   <= fer_d;
      per_q   <= per_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ct_d    = ct_q;
    cb_d    = cb_q;
    sh_d    = sh_q;
    dat_d   = dat_q;
    fe_d    = fe_q;
    pe_d    = pe_q;
    ok_d    = 1'b0;
    fer_d   = 1'b0;
    per_d   = 1'b0;
    fe_stop = fe_q | ~samp;

    if (ce_tact) ct_d = (ct_q == CT_MAX) ? '0 : ct_q + CT_W'(1);
    if (en_rx_byte && ce_tact && (ct_q == CT_MAX)) cb_d = cb_q + 4'd1;

    case (state_q)
      S_IDLE: begin
        if (ce_tact && !rxd_q) begin
          ct_d    = '0;
          cb_d    = '0;
          fe_d    = 1'b0;
          pe_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (ce_bit) state_d = samp ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (ce_bit) begin
          sh_d = {samp, sh_q[DATA_BITS-1:1]};
          if (cb_q == CB_LAST_DATA) state_d = (PARITY != 0) ? S_PAR : S_STOP;
        end
      end
      S_PAR: begin
        if (ce_bit) begin
          pe_d    = samp ^ par_exp;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (ce_bit) begin
          fe_d = fe_stop;
          if (cb_q == CB_LAST_STOP) begin
            dat_d   = sh_q;
            fer_d   = fe_stop;
            per_d   = pe_q;
            ok_d    = ~fe_stop & ~pe_q;
            state_d = samp ? S_IDLE : S_BRK;
          end
        end
      end
      S_BRK: begin
        if (ce_tact && rxd_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign en_rx_byte = (state_q == S_START) || (state_q == S_DATA) ||
                      (state_q == S_PAR)   || (state_q == S_STOP);
  assign dat        = dat_q;
  assign ok_rx_byte = ok_q;
  assign err_frame  = fer_q;
  assign err_parity = per_q;
  assign cb_bit     = cb_q;
  assign RXD        = rxd_q;

endmodule
